// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: 11-bit frame deserialiser with E0/F0 prefix tracking,
// stalled-frame timeout and scancode-to-ASCII translation.
// Optional build macro PS2_PARITY_CHECK_EN: also reject frames with even parity.
module ps2_keyboard_receiver #(
    parameter int clk_mhz    = 50,
    parameter int timeout_us = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_valid,
    output logic [7:0] ps2_scancode,
    output logic [7:0] ps2_ascii,
    output logic       ps2_break,
    output logic       ps2_extended,
    output logic       ps2_error
);
    localparam int TO_LIMIT = clk_mhz * timeout_us;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_clk_s1, r_clk_s2, r_clk_s3;
    logic            r_dat_s1, r_dat_s2;
    logic [8:0]      r_frame;     // {parity, d7..d0} once PARITY has been shifted in
    logic [2:0]      r_bitcnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext, r_brk;
    logic            r_valid, r_error;
    logic [7:0]      r_scancode, r_ascii;
    logic            r_break, r_extended;

    logic            w_fall, w_timeout, w_stop_edge, w_frame_good;
    logic [7:0]      w_byte;

    function automatic logic [7:0] f_ascii(input logic [7:0] sc);
        case (sc)
            8'h45: f_ascii = 8'h30;  8'h16: f_ascii = 8'h31;  8'h1E: f_ascii = 8'h32;
            8'h26: f_ascii = 8'h33;  8'h25: f_ascii = 8'h34;  8'h2E: f_ascii = 8'h35;
            8'h36: f_ascii = 8'h36;  8'h3D: f_ascii = 8'h37;  8'h3E: f_ascii = 8'h38;
            8'h46: f_ascii = 8'h39;
            8'h1C: f_ascii = 8'h41;  8'h32: f_ascii = 8'h42;  8'h21: f_ascii = 8'h43;
            8'h23: f_ascii = 8'h44;  8'h24: f_ascii = 8'h45;  8'h2B: f_ascii = 8'h46;
            8'h34: f_ascii = 8'h47;  8'h33: f_ascii = 8'h48;  8'h43: f_ascii = 8'h49;
            8'h3B: f_ascii = 8'h4A;  8'h42: f_ascii = 8'h4B;  8'h4B: f_ascii = 8'h4C;
            8'h3A: f_ascii = 8'h4D;  8'h31: f_ascii = 8'h4E;  8'h44: f_ascii = 8'h4F;
            8'h4D: f_ascii = 8'h50;  8'h15: f_ascii = 8'h51;  8'h2D: f_ascii = 8'h52;
            8'h1B: f_ascii = 8'h53;  8'h2C: f_ascii = 8'h54;  8'h3C: f_ascii = 8'h55;
            8'h2A: f_ascii = 8'h56;  8'h1D: f_ascii = 8'h57;  8'h22: f_ascii = 8'h58;
            8'h35: f_ascii = 8'h59;  8'h1A: f_ascii = 8'h5A;
            8'h29: f_ascii = 8'h20;  8'h5A: f_ascii = 8'h0D;  8'h66: f_ascii = 8'h08;
            default: f_ascii = 8'h00;
        endcase
    endfunction

    assign w_fall = r_clk_s3 & ~r_clk_s2;
    assign w_byte = r_frame[7:0];

    // Two-flop synchronisers plus one history flop for falling-edge detection; idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1; r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;  r_clk_s2 <= r_clk_s1; r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data; r_dat_s2 <= r_dat_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state; a PS/2 edge takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_stop_edge  = 1'b0;
        w_timeout    = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_W'(TO_LIMIT));
`ifdef PS2_PARITY_CHECK_EN
        w_frame_good = r_dat_s2 & (^r_frame);
`else
        w_frame_good = r_dat_s2;
`endif
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_stop_edge = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Idle timer: restarts on every PS/2 clock fall, frozen at zero in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           r_to_cnt <= '0;
        else if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
        else                                r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Shift register and bit counter: data LSB first, then the parity bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame  <= '0;
            r_bitcnt <= '0;
        end else if (w_fall) begin
            if (r_state == S_IDLE) r_bitcnt <= '0;
            if (r_state == S_DATA || r_state == S_PARITY) r_frame <= {r_dat_s2, r_frame[8:1]};
            if (r_state == S_DATA) r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    // Frame completion: prefix tracking, output registers and one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext <= 1'b0; r_brk <= 1'b0;
            r_valid <= 1'b0; r_error <= 1'b0;
            r_scancode <= '0; r_ascii <= '0;
            r_break <= 1'b0; r_extended <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (w_timeout || (w_stop_edge && !w_frame_good)) begin
                r_error <= 1'b1;
                r_ext   <= 1'b0;
                r_brk   <= 1'b0;
            end else if (w_stop_edge) begin
                if (w_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (w_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_valid    <= 1'b1;
                    r_scancode <= w_byte;
                    r_ascii    <= r_ext ? 8'h00 : f_ascii(w_byte);
                    r_break    <= r_brk;
                    r_extended <= r_ext;
                    r_ext      <= 1'b0;
                    r_brk      <= 1'b0;
                end
            end
        end
    end

    assign ps2_valid    = r_valid;
    assign ps2_error    = r_error;
    assign ps2_scancode = r_scancode;
    assign ps2_ascii    = r_ascii;
    assign ps2_break    = r_break;
    assign ps2_extended = r_extended;
endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Self-checking bench for ps2_keyboard_receiver: frame vectors table plus
// hand-written reset, latency and timeout sequences.
module tb_ps2_keyboard_receiver;
    localparam int FAST = 50;    // half PS/2 period in clk cycles (1 us)
    localparam int SLOW = 2000;  // 40 us half period -> 12.5 kHz

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2_valid, ps2_break, ps2_extended, ps2_error;
    logic [7:0] ps2_scancode, ps2_ascii;

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;

    ps2_keyboard_receiver #(.clk_mhz(50), .timeout_us(100)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_valid(ps2_valid), .ps2_scancode(ps2_scancode), .ps2_ascii(ps2_ascii),
        .ps2_break(ps2_break), .ps2_extended(ps2_extended), .ps2_error(ps2_error)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (ps2_valid) vcnt <= vcnt + 1;
        if (ps2_error) ecnt <= ecnt + 1;
        if (ps2_valid && ps2_error) both <= both + 1;
    end

    typedef struct {
        logic [7:0] code;
        bit         flip_par;
        bit         bad_stop;
        int         half;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_sc;
        logic [7:0] exp_asc;
        bit         exp_brk;
        bit         exp_ext;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [7:0] code, bit fp, bit bs, int half, int ev, int ee,
                                logic [7:0] sc, logic [7:0] asc, bit brk, bit ext);
        vec_t v;
        v.code = code; v.flip_par = fp; v.bad_stop = bs; v.half = half;
        v.exp_v = ev; v.exp_e = ee; v.exp_sc = sc; v.exp_asc = asc;
        v.exp_brk = brk; v.exp_ext = ext;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int half);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit fp, input bit bs, input int half);
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(code[i], half);
        send_bit((~^code) ^ fp, half);
        send_bit(~bs, half);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] sc, input logic [7:0] asc,
                            input bit brk, input bit ext);
        chk({tag, ".scancode"}, 32'(ps2_scancode), 32'(sc));
        chk({tag, ".ascii"},    32'(ps2_ascii),    32'(asc));
        chk({tag, ".break"},    32'(ps2_break),    32'(brk));
        chk({tag, ".extended"}, 32'(ps2_extended), 32'(ext));
    endtask

    initial begin
        int v0, e0, t;
        bit seen;

        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset.valid", 32'(ps2_valid), 0);
        chk("reset.error", 32'(ps2_error), 0);
        chk_outs("reset", 8'h00, 8'h00, 0, 0);

        // A good frame, then reset mid-frame clears everything
        send_frame(8'h29, 0, 0, FAST);
        chk_outs("pre_rst", 8'h29, 8'h20, 0, 0);
        send_bit(1'b0, FAST);
        send_bit(1'b1, FAST);
        ps2_data = 1'b0;
        repeat (FAST) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_outs("midrst", 8'h00, 8'h00, 0, 0);
        v0 = vcnt;
        send_frame(8'h16, 0, 0, FAST);
        chk("after_rst.vcount", 32'(vcnt - v0), 1);
        chk_outs("after_rst", 8'h16, 8'h31, 0, 0);

        // Table of frames with expected state after each
        vt.push_back(mk(8'h1C, 0, 0, SLOW, 1, 0, 8'h1C, 8'h41, 0, 0));
        vt.push_back(mk(8'hF0, 0, 0, FAST, 0, 0, 8'h1C, 8'h41, 0, 0));
        vt.push_back(mk(8'h1C, 0, 0, FAST, 1, 0, 8'h1C, 8'h41, 1, 0));
        vt.push_back(mk(8'h45, 0, 0, FAST, 1, 0, 8'h45, 8'h30, 0, 0));
        vt.push_back(mk(8'hE0, 0, 0, FAST, 0, 0, 8'h45, 8'h30, 0, 0));
        vt.push_back(mk(8'h75, 0, 0, FAST, 1, 0, 8'h75, 8'h00, 0, 1));
        vt.push_back(mk(8'h29, 0, 0, FAST, 1, 0, 8'h29, 8'h20, 0, 0));
        vt.push_back(mk(8'h66, 0, 0, FAST, 1, 0, 8'h66, 8'h08, 0, 0));
        vt.push_back(mk(8'hF0, 0, 0, FAST, 0, 0, 8'h66, 8'h08, 0, 0));
        vt.push_back(mk(8'h22, 0, 1, FAST, 0, 1, 8'h66, 8'h08, 0, 0));
        vt.push_back(mk(8'h5A, 0, 0, FAST, 1, 0, 8'h5A, 8'h0D, 0, 0));
        vt.push_back(mk(8'hE0, 0, 0, FAST, 0, 0, 8'h5A, 8'h0D, 0, 0));
        vt.push_back(mk(8'h1A, 0, 0, FAST, 1, 0, 8'h1A, 8'h00, 0, 1));
        vt.push_back(mk(8'h0E, 0, 0, FAST, 1, 0, 8'h0E, 8'h00, 0, 0));
        vt.push_back(mk(8'h1A, 0, 0, FAST, 1, 0, 8'h1A, 8'h5A, 0, 0));
`ifdef PS2_PARITY_CHECK_EN
        vt.push_back(mk(8'h1C, 1, 0, FAST, 0, 1, 8'h1A, 8'h5A, 0, 0));
`else
        vt.push_back(mk(8'h1C, 1, 0, FAST, 1, 0, 8'h1C, 8'h41, 0, 0));
`endif

        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("vec%0d_%02h", i, vt[i].code);
            v0 = vcnt;
            e0 = ecnt;
            send_frame(vt[i].code, vt[i].flip_par, vt[i].bad_stop, vt[i].half);
            chk({tag, ".vcount"}, 32'(vcnt - v0), 32'(vt[i].exp_v));
            chk({tag, ".ecount"}, 32'(ecnt - e0), 32'(vt[i].exp_e));
            chk_outs(tag, vt[i].exp_sc, vt[i].exp_asc, vt[i].exp_brk, vt[i].exp_ext);
        end

        // Latency: valid appears on the 3rd posedge after the stop-bit fall
        send_bit(1'b0, FAST);
        for (int i = 0; i < 8; i++) send_bit(((8'h29 >> i) & 8'h01) != 0, FAST);
        send_bit(1'b0, FAST);          // 0x29 has three ones -> parity 0
        ps2_data = 1'b1;
        repeat (FAST) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk); #1 chk("lat.edge1", 32'(ps2_valid), 0);
        @(posedge clk); #1 chk("lat.edge2", 32'(ps2_valid), 0);
        @(posedge clk); #1 chk("lat.edge3", 32'(ps2_valid), 1);
        @(posedge clk); #1 chk("lat.edge4", 32'(ps2_valid), 0);
        chk_outs("lat", 8'h29, 8'h20, 0, 0);
        repeat (FAST) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (FAST) @(negedge clk);

        // Timeout: start + 4 data bits then stall high for 120 us
        v0 = vcnt;
        e0 = ecnt;
        send_bit(1'b0, FAST);
        send_bit(1'b1, FAST);
        send_bit(1'b0, FAST);
        send_bit(1'b1, FAST);
        ps2_data = 1'b0;
        repeat (FAST) @(negedge clk);
        ps2_clk = 1'b0;                // last fall at a negedge; count posedges from here
        seen = 0;
        t = 0;
        for (int c = 1; c <= 6000; c++) begin
            @(posedge clk); #1;
            if (c == FAST) ps2_clk = 1'b1;
            if (ps2_error && !seen) begin
                seen = 1;
                t = c;
            end
        end
        ps2_data = 1'b1;
        chk("tmo.seen", 32'(seen), 1);
        chk("tmo.in_window", 32'(t >= 5000 && t <= 5010), 1);
        chk("tmo.ecount", 32'(ecnt - e0), 1);
        chk("tmo.vcount", 32'(vcnt - v0), 0);
        chk_outs("tmo", 8'h29, 8'h20, 0, 0);
        v0 = vcnt;
        send_frame(8'h5A, 0, 0, FAST);
        chk("post_tmo.vcount", 32'(vcnt - v0), 1);
        chk_outs("post_tmo", 8'h5A, 8'h0D, 0, 0);

        chk("valid_and_error_overlap", 32'(both), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
